step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Pattern step sequencer upstream of voice: drives its tone_freq and gate ports.
//  Plays a writable pattern RAM of STEPS entries {rest, freq}.
//  Step and gate lengths are counted in ticks from an internal prescaler.
//  Gate always drops at least one tick before each step end, so voice's ADSR retriggers on every note.
// PARAMETERS
//  TICK_DIV   16  clk cycles per tick (>=1); 1 MHz clk with TICK_DIV=1000 gives 1 ms ticks
//  STEPS      16  pattern length; power of 2; AW=log2(STEPS)
//  FREQ_BITS  16  width of tone_freq, matching voice
// PORTS
//  clk          in   1          system clock (voice clock domain)
//  rst          in   1          synchronous, active-high reset
//  run          in   1          1=play, 0=stop
//  step_ticks   in   8          step length in ticks; 0 treated as 1
//  gate_ticks   in   8          gate-high length in ticks; 0 means every step is silent
//  last_step    in   AW         loop end index; wraps to step 0 after this step
//  wr_en        in   1          pattern write strobe
//  wr_addr      in   AW         pattern write address
//  wr_data      in   1+FREQ_BITS  {rest, freq}
//  tone_freq    out  FREQ_BITS  to voice.tone_freq
//  gate         out  1          to voice.gate
//  step_idx     out  AW         index of the step currently playing
//  step_strobe  out  1          1-clk pulse on every step load
// BEHAVIOUR
//  Reset (rst=1 at clk edge) clears outputs and state:
//   tone_freq=0, gate=0, step_idx=0, step_strobe=0, prescaler=0, tick count=0, state=IDLE.
//   Pattern RAM is not cleared.
//  Prescaler: counts 0..TICK_DIV-1 while not IDLE; tick pulse on the TICK_DIV-1 cycle.
//   Cleared on every step load.
//  States IDLE, GATE_ON, GATE_OFF; tc = tick count within the current step.
//  Derived lengths: step_len = max(step_ticks,1); gate_eff = min(gate_ticks, step_len-1).
//  Step load, performed in one clk:
//   tone_freq<=freq[i]; step_idx<=i; step_strobe<=1; tc<=0; prescaler<=0.
//   gate<=(~rest[i] && gate_eff!=0); next state GATE_ON if gate set, else GATE_OFF.
//  IDLE: gate=0; tone_freq holds its last value so the release phase sounds.
//   run=1 -> load step 0.
//  GATE_ON: on tick, tc++. On the tick where tc+1==gate_eff: gate<=0, go GATE_OFF.
//   Gate is therefore high for exactly gate_eff*TICK_DIV clks.
//  GATE_OFF: on tick, tc++. On the tick where tc+1==step_len: load next step.
//   Next step = (step_idx>=last_step) ? 0 : step_idx+1.
//   Step period is exactly step_len*TICK_DIV clks.
//   step_len=1 gives gate_eff=0, so the gate stays low.
//  run=0 in any non-IDLE state: next clk gate=0, state=IDLE, step_strobe=0.
//   Restart always begins at step 0.
//  Priority: rst > run=0 > step-end load > gate-off.
//  Pattern write: wr_en writes RAM[wr_addr] at the clk edge.
//   A write to the playing step does not alter the current tone_freq; it takes effect at that step's next load.
//   Write and load of the same address on the same clk: the load uses the OLD data.
//  step_ticks, gate_ticks, last_step are sampled live each clk; changes apply from the next comparison.
//   Lowering last_step below step_idx wraps to 0 at the current step's end.
//  Latency: run 0->1 to gate=1 (non-rest step 0) is 1 clk.
// CONFIGURATION
//  STEP_SEQ_SWING_EN defined:
//   Adds input swing_ticks [7:0].
//   Steps with odd step_idx use step_len = max(step_ticks,1)+swing_ticks (9-bit compare, no overflow).
//   gate_eff is unchanged, so extra swing time is gate-low.
//  STEP_SEQ_SWING_EN undefined:
//   Port is absent; all steps use max(step_ticks,1).
// TESTING (TICK_DIV=4 in bench)
//  1. Reset: assert rst 2 clks with run=1 -> gate=0, tone_freq=0, step_idx=0, step_strobe=0; RAM untouched.
//  2. Basic loop: RAM[0..3]=16'd100,200,300,400; last_step=3; step_ticks=4; gate_ticks=2; run=1.
//     -> step_strobe every 16 clks; gate high 8 clks per step.
//     -> tone_freq sequence 100,200,300,400,100.
//  3. Rest and clamp: RAM[1] rest=1; gate_ticks=9, step_ticks=4 -> gate high 12 clks on steps 0,2,3; low all of step 1.
//     step_ticks=0 -> 4-clk steps with gate never high.
//  4. Stop mid-gate: run=0 two clks into GATE_ON -> gate=0 next clk; tone_freq held.
//     run=1 again -> step_idx=0, gate=1 after 1 clk.
//  5. Write collision: write RAM[2]=16'd999 on the clk step 2 loads -> old value plays; 999 plays on the next loop.
//  6. STEP_SEQ_SWING_EN: swing_ticks=2, step_ticks=4 -> even steps 16 clks, odd steps 24 clks; gate lengths unchanged.

Source files
------------

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : step_sequencer
//  Purpose  : Pattern step sequencer feeding a voice. Plays a writable
//             pattern RAM of STEPS entries {rest, freq}. Step and gate lengths
//             are counted in ticks from an internal prescaler. The gate always
//             drops at least one tick before each step ends, so the voice
//             ADSR retriggers on every note.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             run                 - 1 = play, 0 = stop (restart from step 0)
//             step_ticks          - step length in ticks (0 treated as 1)
//             gate_ticks          - gate-high length in ticks (0 = silent)
//             last_step           - loop end index
//             wr_en/addr/data     - pattern RAM write port {rest, freq}
//             swing_ticks         - extra ticks on odd steps (swing build only)
//             tone_freq, gate     - to the voice
//             step_idx            - index of the step currently playing
//             step_strobe         - 1-clk pulse on every step load
//  Config   : define STEP_SEQ_SWING_EN to add the swing_ticks input.
//  Revision : 1.0 - initial release
// ============================================================================
module step_sequencer #(
    parameter  int TICK_DIV  = 16,
    parameter  int STEPS     = 16,
    parameter  int FREQ_BITS = 16,
    localparam int AW        = $clog2(STEPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [7:0]           step_ticks,
    input  logic [7:0]           gate_ticks,
    input  logic [AW-1:0]        last_step,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [FREQ_BITS:0]   wr_data,
`ifdef STEP_SEQ_SWING_EN
    input  logic [7:0]           swing_ticks,
`endif
    output logic [FREQ_BITS-1:0] tone_freq,
    output logic                 gate,
    output logic [AW-1:0]        step_idx,
    output logic                 step_strobe
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] c_presc_max = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GATE_ON  = 2'd1,
        S_GATE_OFF = 2'd2
    } state_t;

    // Pattern RAM: bit FREQ_BITS is the rest flag. Not reset.
    logic [FREQ_BITS:0]   r_ram [STEPS];

    state_t               r_state, w_state_nxt;
    logic                 r_gate, w_gate_nxt;
    logic [FREQ_BITS-1:0] r_tone_freq, w_freq_nxt;
    logic [AW-1:0]        r_step_idx, w_idx_nxt;
    logic                 r_strobe, w_strobe_nxt;
    logic [PW-1:0]        r_presc, w_presc_nxt;
    // 9 bits: swing can stretch a step up to 510 ticks
    logic [8:0]           r_tc, w_tc_nxt;

    logic                 w_tick;
    logic [8:0]           w_tc_inc;
    logic [7:0]           w_base_len;
    logic [8:0]           w_step_len;
    logic [7:0]           w_gate_eff;
    logic [AW-1:0]        w_next_idx;
    logic [AW-1:0]        w_load_idx;
    logic [FREQ_BITS:0]   w_rd;
    logic                 w_load;

    assign w_tick     = (r_state != S_IDLE) && (r_presc == c_presc_max);
    assign w_tc_inc   = r_tc + 9'd1;
    assign w_base_len = (step_ticks == 8'd0) ? 8'd1 : step_ticks;

`ifdef STEP_SEQ_SWING_EN
    assign w_step_len = {1'b0, w_base_len} + (r_step_idx[0] ? {1'b0, swing_ticks} : 9'd0);
`else
    assign w_step_len = {1'b0, w_base_len};
`endif

    // Gate length ignores swing, so swing time is always gate-low.
    assign w_gate_eff = (gate_ticks < w_base_len) ? gate_ticks : (w_base_len - 8'd1);
    assign w_next_idx = (r_step_idx >= last_step) ? '0 : (r_step_idx + 1'b1);
    assign w_load_idx = (r_state == S_IDLE) ? '0 : w_next_idx;
    // Read before the write edge: a same-clk write and load sees old data.
    assign w_rd       = r_ram[w_load_idx];

    always_comb begin
        w_state_nxt  = r_state;
        w_gate_nxt   = r_gate;
        w_freq_nxt   = r_tone_freq;
        w_idx_nxt    = r_step_idx;
        w_strobe_nxt = 1'b0;
        w_presc_nxt  = r_presc;
        w_tc_nxt     = r_tc;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_gate_nxt  = 1'b0;
                w_presc_nxt = '0;
                w_tc_nxt    = '0;
                w_load      = run;
            end
            default: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                    w_gate_nxt  = 1'b0;
                    w_presc_nxt = '0;
                    w_tc_nxt    = '0;
                end else begin
                    w_presc_nxt = w_tick ? '0 : (r_presc + 1'b1);
                    if (w_tick) begin
                        w_tc_nxt = w_tc_inc;
                        // >= keeps the FSM safe if lengths shrink mid-step
                        if (w_tc_inc >= w_step_len) begin
                            w_load = 1'b1;
                        end else if ((r_state == S_GATE_ON) &&
                                     (w_tc_inc >= {1'b0, w_gate_eff})) begin
                            w_gate_nxt  = 1'b0;
                            w_state_nxt = S_GATE_OFF;
                        end
                    end
                end
            end
        endcase

        if (w_load) begin
            w_freq_nxt   = w_rd[FREQ_BITS-1:0];
            w_idx_nxt    = w_load_idx;
            w_strobe_nxt = 1'b1;
            w_tc_nxt     = '0;
            w_presc_nxt  = '0;
            w_gate_nxt   = ~w_rd[FREQ_BITS] && (w_gate_eff != 8'd0);
            w_state_nxt  = w_gate_nxt ? S_GATE_ON : S_GATE_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gate      <= 1'b0;
            r_tone_freq <= '0;
            r_step_idx  <= '0;
            r_strobe    <= 1'b0;
            r_presc     <= '0;
            r_tc        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gate      <= w_gate_nxt;
            r_tone_freq <= w_freq_nxt;
            r_step_idx  <= w_idx_nxt;
            r_strobe    <= w_strobe_nxt;
            r_presc     <= w_presc_nxt;
            r_tc        <= w_tc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_ram[wr_addr] <= wr_data;
        end
    end

    assign tone_freq   = r_tone_freq;
    assign gate        = r_gate;
    assign step_idx    = r_step_idx;
    assign step_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_sequencer
//  Purpose  : Directed self-checking bench for step_sequencer (TICK_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;

    localparam int TICK_DIV = 4;
    localparam int STEPS    = 16;
    localparam int FB       = 16;
    localparam int AW       = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [7:0]    step_ticks;
    logic [7:0]    gate_ticks;
    logic [AW-1:0] last_step;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [FB:0]   wr_data;
    logic [7:0]    swing_ticks;
    logic [FB-1:0] tone_freq;
    logic          gate;
    logic [AW-1:0] step_idx;
    logic          step_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    step_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .STEPS     (STEPS),
        .FREQ_BITS (FB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step_ticks  (step_ticks),
        .gate_ticks  (gate_ticks),
        .last_step   (last_step),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef STEP_SEQ_SWING_EN
        .swing_ticks (swing_ticks),
`endif
        .tone_freq   (tone_freq),
        .gate        (gate),
        .step_idx    (step_idx),
        .step_strobe (step_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Called on a strobe sample: counts clks to the next strobe and gate-high clks.
    task automatic measure(output int len, output int gclk);
        int  p;
        int  g;
        bit  done;
        p    = 1;
        g    = int'(gate);
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            cyc();
            if (step_strobe) done = 1'b1;
            else begin
                p++;
                g += int'(gate);
            end
        end
        if (!done) check("strobe_timeout", 0, 1);
        len  = p;
        gclk = g;
    endtask

    task automatic write_ram(input int addr, input logic [FB:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        cyc();
    endtask

    int len, gc;
    int exp_freq [4] = '{100, 200, 300, 400};
    int exp_gate3[4] = '{12, 0, 12, 12};
    int odd_extra;

    initial begin
        rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        step_ticks = 8'd4; gate_ticks = 8'd2; last_step = 4'd3; swing_ticks = 8'd0;
        cyc(); cyc();
        for (int i = 0; i < 4; i++) write_ram(i, {1'b0, 16'(exp_freq[i])});
        rst = 1'b0;
        cyc();

        // ---- 1. reset while playing, run held high
        run = 1'b1;
        cyc(); cyc(); cyc();
        check("pre_rst_gate", int'(gate), 1);
        rst = 1'b1;
        cyc(); cyc();
        check("rst_gate", int'(gate), 0);
        check("rst_freq", int'(tone_freq), 0);
        check("rst_idx", int'(step_idx), 0);
        check("rst_strobe", int'(step_strobe), 0);
        rst = 1'b0;
        cyc();
        check("start_strobe", int'(step_strobe), 1);
        check("start_gate", int'(gate), 1);

        // ---- 2. basic loop: 16-clk steps, 8-clk gate
        for (int k = 0; k < 4; k++) begin
            check("loop_freq", int'(tone_freq), exp_freq[k]);
            check("loop_idx", int'(step_idx), k);
            // mark step 1 as rest for the next test (does not touch step 3)
            if (k == 3) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = {1'b1, 16'd200};
            end
            measure(len, gc);
            check("loop_len", len, 16);
            check("loop_gate", gc, 8);
        end
        check("wrap_freq", int'(tone_freq), 100);
        check("wrap_idx", int'(step_idx), 0);

        // ---- 3. rest and gate clamp (min(9, 3) = 3 ticks)
        gate_ticks = 8'd9;
        for (int k = 0; k < 4; k++) begin
            check("clamp_idx", int'(step_idx), k);
            check("clamp_freq", int'(tone_freq), exp_freq[k]);
            measure(len, gc);
            check("clamp_len", len, 16);
            check("clamp_gate", gc, exp_gate3[k]);
        end
        step_ticks = 8'd0;
        measure(len, gc);
        check("st0_first_len", len, 4);
        for (int k = 1; k < 3; k++) begin
            check("st0_idx", int'(step_idx), k);
            measure(len, gc);
            check("st0_len", len, 4);
            check("st0_gate", gc, 0);
        end

        // ---- 4. stop and restart
        step_ticks = 8'd4; gate_ticks = 8'd2;
        run = 1'b0;
        cyc();
        check("stop_gate", int'(gate), 0);
        check("stop_freq_held", int'(tone_freq), 400);
        run = 1'b1;
        cyc();
        check("restart_idx", int'(step_idx), 0);
        check("restart_gate", int'(gate), 1);
        check("restart_freq", int'(tone_freq), 100);
        cyc(); cyc();
        check("mid_gate", int'(gate), 1);
        run = 1'b0;
        cyc();
        check("midstop_gate", int'(gate), 0);
        check("midstop_freq", int'(tone_freq), 100);
        check("midstop_strobe", int'(step_strobe), 0);
        cyc();
        check("idle_gate", int'(gate), 0);
        run = 1'b1;
        cyc();
        check("rerun_idx", int'(step_idx), 0);
        check("rerun_gate", int'(gate), 1);
        check("rerun_strobe", int'(step_strobe), 1);

        // ---- 5. write collision on step 2 load
        measure(len, gc);
        check("col_idx1", int'(step_idx), 1);
        for (int i = 0; i < 15; i++) cyc();
        check("col_pre_strobe", int'(step_strobe), 0);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = {1'b0, 16'd999};
        cyc();
        check("col_strobe", int'(step_strobe), 1);
        check("col_old_freq", int'(tone_freq), 300);
        measure(len, gc);
        measure(len, gc);
        measure(len, gc);
        measure(len, gc);
        check("col_new_idx", int'(step_idx), 2);
        check("col_new_freq", int'(tone_freq), 999);

        // ---- 6. swing (odd steps +2 ticks when the feature is built in)
        swing_ticks = 8'd2;
`ifdef STEP_SEQ_SWING_EN
        odd_extra = 8;
`else
        odd_extra = 0;
`endif
        measure(len, gc);
        check("sw_even_len", len, 16);
        check("sw_even_gate", gc, 8);
        measure(len, gc);
        check("sw_odd_len", len, 16 + odd_extra);
        check("sw_odd_gate", gc, 8);
        measure(len, gc);
        check("sw_even0_len", len, 16);
        measure(len, gc);
        check("sw_rest_len", len, 16 + odd_extra);
        check("sw_rest_gate", gc, 0);

        // ---- lowering last_step below the playing index wraps at step end
        swing_ticks = 8'd0;
        check("ls_idx2", int'(step_idx), 2);
        last_step = 4'd1;
        measure(len, gc);
        check("ls_wrap_idx", int'(step_idx), 0);
        measure(len, gc);
        check("ls_idx1", int'(step_idx), 1);
        measure(len, gc);
        check("ls_wrap2_idx", int'(step_idx), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
